example_sched: RTL and testbench
================================

Name: example_sched

Overview:
- Round-robin scheduler that shares one Example encoder between N_REQ requesters.
- Grants one requester at a time and sequences it through one header beat, then LEN data beats.
- Waits for the encoder's code word and returns it tagged with the requester ID.
- Sits between the requester front-ends and the Example encoder; drives its header/data inputs and consumes its code outputs.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- LEN_W, 8, width of each per-request data-beat count.
- TIMEOUT, 64, maximum WAIT-state cycles before a transaction is aborted.
- ID_W, $clog2(N_REQ), width of the requester index.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request pending.
- req_header  in  N_REQ*32  header per requester; slice i at bits [32*i+31:32*i].
- req_len  in  N_REQ*LEN_W  data-beat count per requester; 0 means header only.
- req_ready  out  N_REQ  one-hot grant pulse; the header and length are captured in this cycle.
- dat_valid  in  N_REQ  per-requester data beat valid.
- dat_bus  in  N_REQ*32  per-requester data word.
- dat_ready  out  N_REQ  one-hot; high only for the granted requester while in DATA.
- o_header_bus  out  32  to encoder i_header_bus.
- o_header_valid  out  1  to encoder i_header_valid.
- o_data_bus  out  32  to encoder i_data_bus.
- o_data_valid  out  1  to encoder i_data_valid.
- i_code_bus  in  32  from encoder o_code_bus.
- i_code_valid  in  1  from encoder o_code_valid.
- res_code  out  32  returned code word.
- res_id  out  ID_W  requester index the result belongs to.
- res_err  out  1  set when the result is a timeout abort.
- res_valid  out  1  one-cycle result strobe; no backpressure.

Behaviour:
- Reset values:
  - all outputs 0; state = IDLE.
  - last_grant = N_REQ-1, so requester 0 has first priority.
  - beat and timeout counters = 0.
- Reset mid-transaction: aborts immediately. No res_valid is produced and no further encoder beats are driven.
- FSM states: IDLE, HDR, DATA, WAIT.
- IDLE:
  - Winner = first i with req_valid[i] = 1, searching from last_grant+1 upward with wrap-around.
  - In the same cycle:
    - req_ready[winner] = 1 (combinational);
    - latch header, len and winner ID;
    - last_grant <= winner;
    - next state = HDR.
  - If no request is pending, stay in IDLE.
- HDR (exactly 1 cycle):
  - o_header_valid = 1; o_header_bus = latched header.
  - Next state: DATA if len != 0, else WAIT. The beat counter loads len.
- DATA:
  - dat_ready[gnt] = 1. A beat is accepted when dat_valid[gnt] = 1.
  - Each accepted beat is registered: o_data_valid = 1 with o_data_bus = the beat's word on the following cycle (1-cycle latency).
  - o_data_valid = 0 on cycles with no accepted beat; stalls are allowed for any length.
  - The beat counter decrements on each accepted beat.
  - When the beat that brings the counter to 0 is accepted, go to WAIT. dat_ready drops on the next cycle.
  - Data from non-granted requesters is ignored.
- WAIT:
  - The timeout counter clears on entry and increments each cycle.
  - If i_code_valid = 1:
    - res_valid = 1, res_code = i_code_bus, res_id = gnt, res_err = 0, registered (1 cycle after i_code_valid);
    - next state = IDLE.
  - Else, when the counter reaches TIMEOUT-1:
    - res_valid = 1, res_code = 0, res_id = gnt, res_err = 1;
    - next state = IDLE.
  - If i_code_valid and timeout occur in the same cycle, i_code_valid wins.
- i_code_valid outside WAIT is ignored.
- New grants are made only in IDLE. Minimum turnaround between two len=0 transactions is IDLE→HDR→WAIT→IDLE plus encoder latency.
- req_valid dropping after grant has no effect; the transaction completes from the latched values.
- res_code, res_id and res_err hold their values until the next res_valid.

Test Plan:
- Single request, len=3: requester 2, header 0xA5A5_0001, data 0x11/0x22/0x33, encoder returns 0xDEAD_BEEF after 2 cycles -> required response:
  - req_ready = 4'b0100 for one cycle;
  - o_header_valid for 1 cycle carrying 0xA5A5_0001;
  - three o_data_valid pulses in order 0x11/0x22/0x33;
  - res_valid with res_code = 0xDEAD_BEEF, res_id = 2, res_err = 0.
- All four requesters valid from reset, len=1 each -> grants in order 0,1,2,3,0; res_id follows the same order.
- len=0, header 0x0000_00FF -> HDR goes straight to WAIT; no o_data_valid pulse; result returned normally.
- Encoder never asserts i_code_valid -> exactly 64 cycles after WAIT entry:
  - res_valid = 1, res_err = 1, res_code = 0;
  - FSM back in IDLE and accepting the next request.
- Data stalls: len=2 with dat_valid low 5 cycles between beats -> o_data_valid has exactly 2 pulses; dat_ready[gnt] stays high throughout DATA.
- Reset in the DATA state after 1 of 4 beats -> all outputs 0 immediately; no res_valid. After release, requester 0 has priority again.

Source files
------------

// File: rtl/example_sched.sv
// example_sched: round-robin scheduler sharing one Example encoder among
// N_REQ requesters. A granted requester is sequenced through one header
// beat and LEN data beats. The encoder's code word is then returned,
// tagged with the requester index, or an error result is returned on timeout.
//
// Handshake semantics (all interfaces): a transfer happens on a rising edge
// where both valid and ready are high. req_ready and dat_ready are one-hot
// and depend on the FSM state. The encoder side and the result side have
// no backpressure: o_*_valid and res_valid are single-cycle strobes.
module example_sched #(
    parameter int N_REQ   = 4,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*32-1:0]    req_header,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ-1:0]       dat_valid,
    input  logic [N_REQ*32-1:0]    dat_bus,
    output logic [N_REQ-1:0]       dat_ready,
    output logic [31:0]            o_header_bus,
    output logic                   o_header_valid,
    output logic [31:0]            o_data_bus,
    output logic                   o_data_valid,
    input  logic [31:0]            i_code_bus,
    input  logic                   i_code_valid,
    output logic [31:0]            res_code,
    output logic [ID_W-1:0]        res_id,
    output logic                   res_err,
    output logic                   res_valid,
    output logic [1:0]             dbg_state_o
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  last_grant_q;
    logic [ID_W-1:0]  gnt_q;
    logic [31:0]      hdr_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [TMO_W-1:0] tmo_q;
    logic             dv_q;
    logic [31:0]      dbus_q;
    logic             res_valid_q;
    logic [31:0]      res_code_q;
    logic [ID_W-1:0]  res_id_q;
    logic             res_err_q;

    logic             win_found;
    logic [ID_W-1:0]  win_id;
    int               idx;
    logic             dat_acc;
    logic             code_hit;
    logic             tmo_hit;

    // Round-robin winner search, starting just after the last grant.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    assign dat_acc  = (state_q == S_DATA) && dat_valid[gnt_q];
    assign code_hit = (state_q == S_WAIT) && i_code_valid;
    assign tmo_hit  = (state_q == S_WAIT) && !i_code_valid &&
                      (tmo_q == TMO_W'(TIMEOUT - 1));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (win_found) state_d = S_HDR;
            S_HDR:  state_d = (len_q != '0) ? S_DATA : S_WAIT;
            S_DATA: if (dat_acc && cnt_q == LEN_W'(1)) state_d = S_WAIT;
            S_WAIT: if (code_hit || tmo_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; the grant pulse is masked while reset is held so every output reads 0.
    always_comb begin
        req_ready      = '0;
        dat_ready      = '0;
        o_header_valid = 1'b0;
        o_header_bus   = '0;
        case (state_q)
            S_IDLE: if (win_found && !rst) req_ready[win_id] = 1'b1;
            S_HDR: begin
                o_header_valid = 1'b1;
                o_header_bus   = hdr_q;
            end
            S_DATA: dat_ready[gnt_q] = 1'b1;
            default: ;
        endcase
    end

    // Capture the winner's request on the grant cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= ID_W'(N_REQ - 1);
            gnt_q        <= '0;
            hdr_q        <= '0;
            len_q        <= '0;
        end else if (state_q == S_IDLE && win_found) begin
            last_grant_q <= win_id;
            gnt_q        <= win_id;
            hdr_q        <= req_header[32*win_id +: 32];
            len_q        <= req_len[LEN_W*win_id +: LEN_W];
        end
    end

    // Beat counter loads in HDR; timeout counter runs only while in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= '0;
        end else begin
            if (state_q == S_HDR) cnt_q <= len_q;
            else if (dat_acc)     cnt_q <= cnt_q - LEN_W'(1);
            if (state_q == S_WAIT) tmo_q <= tmo_q + TMO_W'(1);
            else                   tmo_q <= '0;
        end
    end

    // Accepted data beats reach the encoder one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_q   <= 1'b0;
            dbus_q <= '0;
        end else begin
            dv_q <= dat_acc;
            if (dat_acc) dbus_q <= dat_bus[32*gnt_q +: 32];
        end
    end

    // Result register: a code word beats a simultaneous timeout; fields hold between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_code_q  <= '0;
            res_id_q    <= '0;
            res_err_q   <= 1'b0;
        end else begin
            res_valid_q <= code_hit || tmo_hit;
            if (code_hit) begin
                res_code_q <= i_code_bus;
                res_id_q   <= gnt_q;
                res_err_q  <= 1'b0;
            end else if (tmo_hit) begin
                res_code_q <= '0;
                res_id_q   <= gnt_q;
                res_err_q  <= 1'b1;
            end
        end
    end

    assign o_data_valid = dv_q;
    assign o_data_bus   = dbus_q;
    assign res_valid    = res_valid_q;
    assign res_code     = res_code_q;
    assign res_id       = res_id_q;
    assign res_err      = res_err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_example_sched.sv
// Directed testbench for example_sched: inputs are driven 1 ns after the
// rising edge, and outputs are checked on the falling edge.
module tb_example_sched;

    localparam int N_REQ = 4;
    localparam int LEN_W = 8;
    localparam int ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*32-1:0]    req_header;
    logic [N_REQ*LEN_W-1:0] req_len;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       dat_valid;
    logic [N_REQ*32-1:0]    dat_bus;
    logic [N_REQ-1:0]       dat_ready;
    logic [31:0]            o_header_bus;
    logic                   o_header_valid;
    logic [31:0]            o_data_bus;
    logic                   o_data_valid;
    logic [31:0]            i_code_bus;
    logic                   i_code_valid;
    logic [31:0]            res_code;
    logic [ID_W-1:0]        res_id;
    logic                   res_err;
    logic                   res_valid;
    logic [1:0]             dbg_state;

    int checks = 0;
    int errors = 0;
    int dv_pulses = 0;
    int res_pulses = 0;

    example_sched #(.N_REQ(N_REQ), .LEN_W(LEN_W), .TIMEOUT(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_header    (req_header),
        .req_len       (req_len),
        .req_ready     (req_ready),
        .dat_valid     (dat_valid),
        .dat_bus       (dat_bus),
        .dat_ready     (dat_ready),
        .o_header_bus  (o_header_bus),
        .o_header_valid(o_header_valid),
        .o_data_bus    (o_data_bus),
        .o_data_valid  (o_data_valid),
        .i_code_bus    (i_code_bus),
        .i_code_valid  (i_code_valid),
        .res_code      (res_code),
        .res_id        (res_id),
        .res_err       (res_err),
        .res_valid     (res_valid),
        .dbg_state_o   (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // pulse counters for encoder data beats and result strobes
    always @(negedge clk) begin
        if (o_data_valid === 1'b1) dv_pulses <= dv_pulses + 1;
        if (res_valid === 1'b1)    res_pulses <= res_pulses + 1;
    end

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pedge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] hdr, input logic [7:0] len);
        req_header[32*i +: 32] = hdr;
        req_len[8*i +: 8]      = len;
    endtask

    int   ord [5] = '{0, 1, 2, 3, 0};
    int   g;
    int   base;
    logic quiet;
    logic stall_ok;

    initial begin
        rst = 1'b1; req_valid = '0; req_header = '0; req_len = '0;
        dat_valid = '0; dat_bus = '0; i_code_bus = '0; i_code_valid = 1'b0;
        repeat (2) @(posedge clk);

        // reset state
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_dat_ready", 32'(dat_ready), 32'h0);
        chk("rst_hdr_valid", 32'(o_header_valid), 32'h0);
        chk("rst_data_valid", 32'(o_data_valid), 32'h0);
        chk("rst_res", {res_valid, res_err, 28'h0, res_id}, 32'h0);
        chk("rst_res_code", res_code, 32'h0);
        chk("rst_state", 32'(dbg_state), 32'h0);
        pedge(); rst = 1'b0;

        // single request, requester 2, len=3
        set_req(2, 32'hA5A5_0001, 8'd3);
        req_valid = 4'b0100;
        @(negedge clk); chk("t1_req_ready", 32'(req_ready), 32'h4);
        pedge(); req_valid = '0;
        @(negedge clk);
        chk("t1_hdr_valid", 32'(o_header_valid), 32'h1);
        chk("t1_hdr_bus", o_header_bus, 32'hA5A5_0001);
        chk("t1_req_ready_drop", 32'(req_ready), 32'h0);
        pedge(); dat_valid = 4'b0100; dat_bus[64 +: 32] = 32'h11;
        @(negedge clk);
        chk("t1_dat_ready", 32'(dat_ready), 32'h4);
        chk("t1_no_dv_yet", 32'(o_data_valid), 32'h0);
        pedge(); dat_bus[64 +: 32] = 32'h22;
        @(negedge clk); chk("t1_beat0", {o_data_valid, o_data_bus[30:0]}, 32'h8000_0011);
        pedge(); dat_bus[64 +: 32] = 32'h33;
        @(negedge clk); chk("t1_beat1", {o_data_valid, o_data_bus[30:0]}, 32'h8000_0022);
        pedge(); dat_valid = '0;
        @(negedge clk);
        chk("t1_beat2", {o_data_valid, o_data_bus[30:0]}, 32'h8000_0033);
        chk("t1_dat_ready_drop", 32'(dat_ready), 32'h0);
        chk("t1_state_wait", 32'(dbg_state), 32'h3);
        pedge();
        @(negedge clk); chk("t1_no_res_early", 32'(res_valid), 32'h0);
        pedge(); i_code_valid = 1'b1; i_code_bus = 32'hDEAD_BEEF;
        @(negedge clk); chk("t1_no_res_yet", 32'(res_valid), 32'h0);
        pedge(); i_code_valid = 1'b0;
        @(negedge clk);
        chk("t1_res_valid", 32'(res_valid), 32'h1);
        chk("t1_res_code", res_code, 32'hDEAD_BEEF);
        chk("t1_res_id_err", {res_err, 29'h0, res_id}, 32'h2);
        chk("t1_state_idle", 32'(dbg_state), 32'h0);
        pedge();
        @(negedge clk);
        chk("t1_res_pulse", 32'(res_valid), 32'h0);
        chk("t1_res_hold", res_code, 32'hDEAD_BEEF);

        // all four requesters from reset, len=1: grants 0,1,2,3,0
        pedge(); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 32'h1000_0000 + 32'(i), 8'd1);
            dat_bus[32*i +: 32] = 32'hD0 + 32'(i);
        end
        req_valid = 4'hF; dat_valid = 4'hF;
        pedge(); rst = 1'b0;
        @(negedge clk); chk("t2_first_grant", 32'(req_ready), 32'h1);
        for (int k = 0; k < 5; k++) begin
            g = ord[k];
            pedge();
            @(negedge clk); chk("t2_hdr", o_header_bus, 32'h1000_0000 + 32'(g));
            pedge();
            @(negedge clk); chk("t2_dat_ready", 32'(dat_ready), 32'(1) << g);
            pedge(); i_code_valid = 1'b1; i_code_bus = 32'hC0DE_0000 + 32'(g);
            @(negedge clk); chk("t2_beat", {o_data_valid, o_data_bus[30:0]}, 32'h8000_00D0 + 32'(g));
            pedge(); i_code_valid = 1'b0;
            if (k == 4) req_valid = '0;
            @(negedge clk);
            chk("t2_res", {res_valid, res_err, 28'h0, res_id}, 32'h8000_0000 | 32'(g));
            chk("t2_res_code", res_code, 32'hC0DE_0000 + 32'(g));
            chk("t2_next_grant", 32'(req_ready), (k < 4) ? (32'(1) << ord[k+1]) : 32'h0);
        end

        // len=0: header straight to WAIT, no data beat
        pedge(); dat_valid = '0;
        set_req(0, 32'h0000_00FF, 8'd0); req_valid = 4'b0001;
        @(negedge clk); chk("t3_req_ready", 32'(req_ready), 32'h1);
        pedge(); req_valid = '0;
        @(negedge clk); chk("t3_hdr", {o_header_valid, o_header_bus[30:0]}, 32'h8000_00FF);
        pedge(); i_code_valid = 1'b1; i_code_bus = 32'h1234_5678;
        @(negedge clk);
        chk("t3_state_wait", 32'(dbg_state), 32'h3);
        chk("t3_no_dv", 32'(o_data_valid), 32'h0);
        pedge(); i_code_valid = 1'b0;
        @(negedge clk);
        chk("t3_res", {res_valid, res_err, 28'h0, res_id}, 32'h8000_0000);
        chk("t3_res_code", res_code, 32'h1234_5678);

        // timeout: encoder never answers
        pedge(); set_req(1, 32'h0BAD_0001, 8'd0); req_valid = 4'b0010;
        @(negedge clk); chk("t4_req_ready", 32'(req_ready), 32'h2);
        pedge(); req_valid = '0;
        pedge();
        @(negedge clk); chk("t4_state_wait", 32'(dbg_state), 32'h3);
        quiet = 1'b1;
        repeat (63) begin
            pedge();
            @(negedge clk);
            if (res_valid !== 1'b0) quiet = 1'b0;
        end
        chk("t4_no_early_res", 32'(quiet), 32'h1);
        chk("t4_code_held", res_code, 32'h1234_5678);
        pedge(); set_req(0, 32'h0000_0042, 8'd0); req_valid = 4'b0001;
        @(negedge clk);
        chk("t4_res", {res_valid, res_err, 28'h0, res_id}, 32'hC000_0001);
        chk("t4_res_code", res_code, 32'h0);
        chk("t4_state_idle", 32'(dbg_state), 32'h0);
        chk("t4_next_grant", 32'(req_ready), 32'h1);
        pedge(); req_valid = '0;
        pedge(); i_code_valid = 1'b1; i_code_bus = 32'h55AA_55AA;
        pedge(); i_code_valid = 1'b0;
        @(negedge clk);
        chk("t4_after_res", {res_valid, res_err, 28'h0, res_id}, 32'h8000_0000);
        chk("t4_after_code", res_code, 32'h55AA_55AA);

        // data stalls: len=2, 5 idle cycles between beats, foreign data ignored
        pedge(); set_req(3, 32'h0000_0305, 8'd2); req_valid = 4'b1000;
        @(negedge clk); chk("t5_req_ready", 32'(req_ready), 32'h8);
        pedge(); req_valid = '0;
        pedge(); dat_valid = 4'b1000; dat_bus[96 +: 32] = 32'hAA; base = dv_pulses;
        @(negedge clk); chk("t5_dat_ready", 32'(dat_ready), 32'h8);
        pedge(); dat_valid = 4'b0001; dat_bus[0 +: 32] = 32'hBB;
        stall_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (dat_ready !== 4'b1000) stall_ok = 1'b0;
            pedge();
        end
        chk("t5_ready_in_stall", 32'(stall_ok), 32'h1);
        dat_valid = 4'b1000; dat_bus[96 +: 32] = 32'hCC;
        @(negedge clk); chk("t5_dat_ready_end", 32'(dat_ready), 32'h8);
        pedge(); dat_valid = '0;
        @(negedge clk);
        chk("t5_last_beat", {o_data_valid, o_data_bus[30:0]}, 32'h8000_00CC);
        chk("t5_dat_ready_drop", 32'(dat_ready), 32'h0);
        pedge(); i_code_valid = 1'b1; i_code_bus = 32'h3333_3333;
        chk("t5_pulse_count", 32'(dv_pulses - base), 32'd2);
        pedge(); i_code_valid = 1'b0;
        @(negedge clk);
        chk("t5_res", {res_valid, res_err, 28'h0, res_id}, 32'h8000_0003);

        // reset in DATA after 1 of 4 beats
        pedge(); set_req(0, 32'h0000_0600, 8'd4); req_valid = 4'b0001;
        @(negedge clk); chk("t6_req_ready", 32'(req_ready), 32'h1);
        pedge(); req_valid = '0;
        pedge(); dat_valid = 4'b0001; dat_bus[0 +: 32] = 32'h61;
        @(negedge clk); chk("t6_dat_ready", 32'(dat_ready), 32'h1);
        pedge();
        dat_valid = '0; rst = 1'b1; req_valid = 4'b0011;
        set_req(0, 32'h0000_0601, 8'd0); set_req(1, 32'h0000_0602, 8'd0);
        base = res_pulses;
        #1;
        chk("t6_rst_dv", {o_data_valid, o_data_bus[30:0]}, 32'h0);
        chk("t6_rst_ready", {dat_ready, req_ready}, 32'h0);
        chk("t6_rst_hdr", 32'(o_header_valid), 32'h0);
        chk("t6_rst_state", 32'(dbg_state), 32'h0);
        repeat (2) pedge();
        rst = 1'b0;
        @(negedge clk); chk("t6_priority0", 32'(req_ready), 32'h1);
        pedge(); req_valid = '0;
        chk("t6_no_res", 32'(res_pulses - base), 32'd0);
        @(negedge clk); chk("t6_hdr", o_header_bus, 32'h0000_0601);
        pedge(); i_code_valid = 1'b1; i_code_bus = 32'h6666_6666;
        pedge(); i_code_valid = 1'b0;
        @(negedge clk);
        chk("t6_res", {res_valid, res_err, 28'h0, res_id}, 32'h8000_0000);
        chk("t6_res_code", res_code, 32'h6666_6666);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
